key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive stable synchronized samples (1 ms at 50 MHz) that qualify a press or a release.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, the number of cycles held before the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_RATE, default 5000000, the number of cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Key_n, input, 1 bit: raw, asynchronous, bouncing push-button pad (low = pressed).
REQ-007 SHALL have port Key_Level, output, 1 bit: debounced key state, active-high.
REQ-008 SHALL have port Key_Pulse, output, 1 bit: one-cycle strobe per qualified press; drives the accumulator Load/Run input.
REQ-009 SHALL have port Press_Count, output, 8 bits: count of Key_Pulse strobes, intended for a HexDriver pair.

Function
REQ-010 SHALL pass Key_n through a two-flop synchronizer and invert it to produce key_s (1 = pressed); no other logic SHALL sample Key_n.
REQ-011 SHALL implement FSM states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-012 IDLE: key_s=1 -> PRESS_WAIT with the stability counter cleared.
REQ-013 PRESS_WAIT: key_s=0 -> IDLE; otherwise the counter increments; when the counter reaches DEBOUNCE_CYCLES-1 with key_s=1 -> HELD.
REQ-014 Entry to HELD from PRESS_WAIT SHALL assert Key_Pulse for exactly one cycle, registered in the first HELD cycle.
REQ-015 HELD: key_s=0 -> RELEASE_WAIT with the stability counter cleared.
REQ-016 RELEASE_WAIT: key_s=1 -> HELD with no Key_Pulse (release bounce); otherwise the counter increments; at DEBOUNCE_CYCLES-1 -> IDLE.
REQ-017 Key_Level SHALL be 1 exactly in HELD and RELEASE_WAIT.
REQ-018 Press_Count SHALL increment by 1 in the cycle after each Key_Pulse, wrapping 8'hFF -> 8'h00.
REQ-019 Press-to-pulse latency SHALL be 2 synchronizer cycles + DEBOUNCE_CYCLES cycles; any glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse and no Key_Level change.
REQ-020 Counters SHALL saturate and never wrap inside a state.

Reset
REQ-021 Reset_n low SHALL asynchronously force: state IDLE, synchronizer flops to the released state, all counters to 0, Key_Level=0, Key_Pulse=0, Press_Count=8'h00.
REQ-022 Reset asserted mid-press SHALL produce no pulse after release of reset until a complete new qualified press occurs.

Configuration
REQ-023 Macro KEY_AUTOREPEAT_EN defined: while in HELD, a repeat counter SHALL issue Key_Pulse after REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
REQ-024 With KEY_AUTOREPEAT_EN, the repeat counter SHALL restart from 0 on every entry to HELD, including a re-entry from RELEASE_WAIT.
REQ-025 Macro KEY_AUTOREPEAT_EN undefined: no repeat logic SHALL be synthesized, and exactly one pulse SHALL be issued per press.

Structure
REQ-026 Package key_cond_pkg SHALL hold the state enum key_state_t and the constant CNT_W=25, the counter width that covers all parameter defaults.
REQ-027 The synchronizer SHALL be sub-module sync_2ff (Clk, Reset_n, D, Q); one instance SHALL be used.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-028 Clean press held for 20 cycles -> Key_Pulse high for exactly one cycle, 6 cycles after the Key_n fall; Press_Count 0 -> 1; Key_Level high.
REQ-029 A 3-cycle low glitch on Key_n -> no Key_Pulse, Key_Level stays 0, Press_Count stays 0.
REQ-030 Release bouncing 1,0,1,0 then stable high -> no extra pulse; Key_Level falls 6 cycles after the last rising edge.
REQ-031 256 clean presses -> Press_Count returns to 8'h00.
REQ-032 Reset_n pulsed low while in HELD -> all outputs 0 immediately, without waiting for Clk; holding the key after reset release yields exactly one new pulse.
REQ-033 With KEY_AUTOREPEAT_EN, key held for 20 cycles after the first pulse -> repeat pulses at +10, +13, +16 and +19 cycles after it; without the macro -> a single pulse.

Source files
------------

// File: rtl/key_cond_pkg.sv
// Shared types and constants for the key conditioner: FSM state encoding,
// counter width and a saturating increment helper.
package key_cond_pkg;

    localparam int CNT_W = 25;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Counters hold at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/key_conditioner_sync_2ff.sv
// Two-flop synchronizer for an asynchronous pad; resets to the released
// (high) level so a held key after reset is seen as a fresh press.
module sync_2ff (
    input  logic Clk,
    input  logic Reset_n,
    input  logic D,
    output logic Q
);

    logic [1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], D};
    end

    assign Q = r_sync[1];

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronize, debounce, one-cycle press strobe and
// an 8-bit press counter. Define KEY_AUTOREPEAT_EN to add hold-to-repeat.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Key_n,
    output logic       Key_Level,
    output logic       Key_Pulse,
    output logic [7:0] Press_Count
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2, repeat timings >= 1");
    end

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_key_n_s;
    logic             w_key_s;
    key_state_t       r_state;
    key_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_level;
    logic             w_press_pulse;
    logic             w_rep_pulse;
    logic             r_pulse;
    logic [7:0]       r_count;

    sync_2ff u_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .D       (Key_n),
        .Q       (w_key_n_s)
    );

    assign w_key_s   = ~w_key_n_s;
    assign w_cnt_inc = sat_inc(r_cnt);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_count <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pulse <= w_press_pulse | w_rep_pulse;
            r_count <= r_count + {7'd0, r_pulse};
        end
    end

    // The entry sample in IDLE/HELD counts as the first stable sample, so the
    // wait states leave once the incremented count reaches DEBOUNCE_CYCLES-1.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_key_s) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_key_s) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc >= DB_LAST) w_state_next = HELD;
                end
            end
            HELD: begin
                if (!w_key_s) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_key_s) begin
                    w_state_next = HELD;
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc >= DB_LAST) w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_level       = (r_state == HELD) || (r_state == RELEASE_WAIT);
        w_press_pulse = (r_state == PRESS_WAIT) && (w_state_next == HELD);
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_FIRST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] r_rep;
    logic             r_rep_armed;
    logic             w_rep_hit;

    // Armed once the first (long) delay has elapsed; later gaps use the rate.
    assign w_rep_hit = (r_state == HELD) && (w_state_next == HELD) &&
                       (r_rep >= (r_rep_armed ? REP_NEXT : REP_FIRST));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rep       <= '0;
            r_rep_armed <= 1'b0;
        end else if (r_state != HELD && w_state_next == HELD) begin
            r_rep       <= '0;
            r_rep_armed <= 1'b0;
        end else if (r_state == HELD) begin
            if (w_rep_hit) begin
                r_rep       <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rep <= sat_inc(r_rep);
            end
        end
    end

    assign w_rep_pulse = w_rep_hit;
`else
    assign w_rep_pulse = 1'b0;
`endif

    assign Key_Level   = w_level;
    assign Key_Pulse   = r_pulse;
    assign Press_Count = r_count;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timings;
// honours KEY_AUTOREPEAT_EN to pick the expected repeat behaviour.
module tb_key_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_n;
    logic       level;
    logic       pulse;
    logic [7:0] count;

    always #5 clk = ~clk;

    key_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .Key_n       (key_n),
        .Key_Level   (level),
        .Key_Pulse   (pulse),
        .Press_Count (count)
    );

    typedef struct {
        logic       key_n;
        logic       level;
        logic       pulse;
        logic [7:0] count;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic bounce_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, actual, expected);
        end
    endtask

    task automatic add(input int n, input logic k, input logic l, input logic p, input logic [7:0] c);
        repeat (n) vecs.push_back('{key_n: k, level: l, pulse: p, count: c});
    endtask

    // Advance n cycles, counting strobes sampled on the falling edge.
    task automatic run(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (pulse === 1'b1) pulses++;
        end
    endtask

    initial begin
        int p;
        int total;
        int first;
        int offs[$];
        int win[$];
        int exp_offs[$];

        rst_n = 1'b0;
        key_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_level", {31'd0, level}, 32'd0);
        check("reset_pulse", {31'd0, pulse}, 32'd0);
        check("reset_count", {24'd0, count}, 32'd0);
        rst_n = 1'b1;

        // idle, 3-cycle glitch, clean press (pulse 6 cycles after fall), release
        add(2, 1'b1, 1'b0, 1'b0, 8'd0);
        add(3, 1'b0, 1'b0, 1'b0, 8'd0);
        add(8, 1'b1, 1'b0, 1'b0, 8'd0);
        add(5, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1, 1'b0, 1'b1, 1'b1, 8'd0);
        add(6, 1'b0, 1'b1, 1'b0, 8'd1);
        add(5, 1'b1, 1'b1, 1'b0, 8'd1);
        add(3, 1'b1, 1'b0, 1'b0, 8'd1);
        foreach (vecs[i]) begin
            key_n = vecs[i].key_n;
            @(negedge clk);
            check($sformatf("vec%0d", i), {22'd0, level, pulse, count},
                  {22'd0, vecs[i].level, vecs[i].pulse, vecs[i].count});
        end

        // release bounce: no extra strobe, level falls 6 cycles after last rise
        key_n = 1'b0;
        run(10, p);
        check("bounce_press_pulses", p, 1);
        total = 0;
        for (int j = 0; j < 4; j++) begin
            key_n = bounce_seq[j];
            run(1, p);
            total += p;
            check($sformatf("bounce_level%0d", j), {31'd0, level}, 32'd1);
        end
        key_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            run(1, p);
            total += p;
            check($sformatf("bounce_fall%0d", j), {31'd0, level}, (j < 5) ? 32'd1 : 32'd0);
        end
        check("bounce_pulses", total, 0);
        check("bounce_count", {24'd0, count}, 32'd2);

        // asynchronous reset while held, mid-strobe
        key_n = 1'b0;
        run(6, p);
        check("pre_reset_pulse", {31'd0, pulse}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_level", {31'd0, level}, 32'd0);
        check("async_pulse", {31'd0, pulse}, 32'd0);
        check("async_count", {24'd0, count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(14, p);
        check("post_reset_pulses", p, 1);
        check("post_reset_count", {24'd0, count}, 32'd1);
        check("post_reset_level", {31'd0, level}, 32'd1);
        key_n = 1'b1;
        run(8, p);

        // long hold: strobe offsets relative to the first strobe
        key_n = 1'b0;
        first = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (pulse === 1'b1) begin
                if (first < 0) first = c;
                offs.push_back(c - first);
            end
            if (first >= 0 && c == first + 20) key_n = 1'b1;
            if (first < 0 && c == 40) break;
        end
        key_n = 1'b1;
        run(10, p);
        check("hold_first_pulse_seen", {31'd0, first >= 0}, 32'd1);
`ifdef KEY_AUTOREPEAT_EN
        exp_offs = '{0, 10, 13, 16, 19};
`else
        exp_offs = '{0};
`endif
        foreach (offs[i]) if (offs[i] <= 20) win.push_back(offs[i]);
        check("hold_pulse_count", win.size(), exp_offs.size());
        foreach (exp_offs[i]) begin
            if (i < win.size()) check($sformatf("hold_offset%0d", i), win[i], exp_offs[i]);
        end

        // 256 clean presses wrap the counter back to zero
        rst_n = 1'b0;
        @(negedge clk);
        check("reset2_count", {24'd0, count}, 32'd0);
        rst_n = 1'b1;
        total = 0;
        for (int k = 0; k < 256; k++) begin
            key_n = 1'b0;
            run(8, p);
            total += p;
            key_n = 1'b1;
            run(8, p);
            total += p;
            if (k == 254) check("count_at_255", {24'd0, count}, 32'd255);
        end
        check("wrap_pulses", total, 256);
        check("wrap_count", {24'd0, count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
